// File: rtl/calc2_engine.sv
`default_nettype none
// ==== calc2_engine : four-port tagged 32-bit calculator, shared ADD/SUB + SHIFT units ====
// ==== Rev 1.0                                                                         ====
module calc2_engine #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [1:0]        req1_tag_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [1:0]        req2_tag_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [1:0]        req3_tag_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req4_data_in,
  input  logic [1:0]        req4_tag_in,
  output logic [1:0]        out_resp1,
  output logic [DATA_W-1:0] out_data1,
  output logic [1:0]        out_tag1,
  output logic [1:0]        out_resp2,
  output logic [DATA_W-1:0] out_data2,
  output logic [1:0]        out_tag2,
  output logic [1:0]        out_resp3,
  output logic [DATA_W-1:0] out_data3,
  output logic [1:0]        out_tag3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data4,
  output logic [1:0]        out_tag4
);
  // FIFO_DEPTH must be a power of two so the pointers wrap naturally.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SH_W  = $clog2(DATA_W);
  localparam int ENT_W = 6 + 2 * DATA_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OP2  = 1'b1;
  localparam logic [3:0] C_ADD  = 4'd1;
  localparam logic [3:0] C_SUB  = 4'd2;
  localparam logic [3:0] C_SHL  = 4'd5;
  localparam logic [3:0] C_SHR  = 4'd6;
  localparam logic [1:0] C_NONE = 2'd0;
  localparam logic [1:0] C_OK   = 2'd1;
  localparam logic [1:0] C_ERR  = 2'd2;

  logic [3:0]        w_cmd  [4];
  logic [DATA_W-1:0] w_data [4];
  logic [1:0]        w_tag  [4];

  logic [0:0]        r_state [4];
  logic [3:0]        r_cmd_l [4];
  logic [1:0]        r_tag_l [4];
  logic [DATA_W-1:0] r_op1_l [4];

  logic [ENT_W-1:0]  r_fifo   [4][FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [4];
  logic [PTR_W-1:0]  r_rd_ptr [4];
  logic [CNT_W-1:0]  r_count  [4];
  logic [ENT_W-1:0]  w_head   [4];
  logic [3:0]        w_head_cmd [4];
  logic [3:0]        w_req_as, w_req_sh, w_push, w_pop;

  logic [1:0]        r_rr_as, r_rr_sh;
  logic [2:0]        w_pick_as, w_pick_sh;

  logic              r_as_vld, r_as_sub;
  logic [1:0]        r_as_port, r_as_tag;
  logic [DATA_W-1:0] r_as_a, r_as_b;
  logic              r_sh_vld;
  logic [3:0]        r_sh_cmd;
  logic [1:0]        r_sh_port, r_sh_tag;
  logic [DATA_W-1:0] r_sh_a;
  logic [SH_W-1:0]   r_sh_amt;

  logic [DATA_W:0]   w_add;
  logic [1:0]        w_as_resp, w_sh_resp;
  logic [DATA_W-1:0] w_as_data, w_sh_data;

  logic [1:0]        r_resp [4];
  logic [DATA_W-1:0] r_dout [4];
  logic [1:0]        r_tago [4];

  assign w_cmd[0] = req1_cmd_in;  assign w_data[0] = req1_data_in;  assign w_tag[0] = req1_tag_in;
  assign w_cmd[1] = req2_cmd_in;  assign w_data[1] = req2_data_in;  assign w_tag[1] = req2_tag_in;
  assign w_cmd[2] = req3_cmd_in;  assign w_data[2] = req3_data_in;  assign w_tag[2] = req3_tag_in;
  assign w_cmd[3] = req4_cmd_in;  assign w_data[3] = req4_data_in;  assign w_tag[3] = req4_tag_in;

  // Returns {valid, port}; scans from the port after 'last' so 'last' itself is tried last.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      w_head[p]     = r_fifo[p][r_rd_ptr[p]];
      w_head_cmd[p] = w_head[p][ENT_W-1 -: 4];
      w_req_as[p]   = (r_count[p] != '0) && (w_head_cmd[p] == C_ADD || w_head_cmd[p] == C_SUB);
      w_req_sh[p]   = (r_count[p] != '0) && !(w_head_cmd[p] == C_ADD || w_head_cmd[p] == C_SUB);
      w_push[p]     = (r_state[p] == S_OP2) && (r_count[p] != CNT_W'(FIFO_DEPTH));
    end
  end

  assign w_pick_as = rr_pick(w_req_as, r_rr_as);
  assign w_pick_sh = rr_pick(w_req_sh, r_rr_sh);

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      w_pop[p] = (w_pick_as[2] && w_pick_as[1:0] == 2'(p)) ||
                 (w_pick_sh[2] && w_pick_sh[1:0] == 2'(p));
    end
  end

  assign w_add = {1'b0, r_as_a} + {1'b0, r_as_b};

  always_comb begin
    w_as_resp = C_OK;
    w_as_data = '0;
    if (r_as_sub) begin
      if (r_as_a < r_as_b) w_as_resp = C_ERR;
      else                 w_as_data = r_as_a - r_as_b;
    end else if (w_add[DATA_W]) begin
      w_as_resp = C_ERR;
    end else begin
      w_as_data = w_add[DATA_W-1:0];
    end
  end

  always_comb begin
    w_sh_resp = C_OK;
    w_sh_data = '0;
    case (r_sh_cmd)
      C_SHL:   w_sh_data = r_sh_a << r_sh_amt;
      C_SHR:   w_sh_data = r_sh_a >> r_sh_amt;
      default: w_sh_resp = C_ERR;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < 4; p++) begin
        r_state[p]  <= S_IDLE;
        r_cmd_l[p]  <= '0;
        r_tag_l[p]  <= '0;
        r_op1_l[p]  <= '0;
        r_wr_ptr[p] <= '0;
        r_rd_ptr[p] <= '0;
        r_count[p]  <= '0;
        r_resp[p]   <= C_NONE;
        r_dout[p]   <= '0;
        r_tago[p]   <= '0;
      end
      r_rr_as   <= 2'd3;
      r_rr_sh   <= 2'd3;
      r_as_vld  <= 1'b0;
      r_as_sub  <= 1'b0;
      r_as_port <= '0;
      r_as_tag  <= '0;
      r_as_a    <= '0;
      r_as_b    <= '0;
      r_sh_vld  <= 1'b0;
      r_sh_cmd  <= '0;
      r_sh_port <= '0;
      r_sh_tag  <= '0;
      r_sh_a    <= '0;
      r_sh_amt  <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (r_state[p] == S_IDLE) begin
          if (w_cmd[p] != 4'd0) begin
            r_cmd_l[p] <= w_cmd[p];
            r_tag_l[p] <= w_tag[p];
            r_op1_l[p] <= w_data[p];
            r_state[p] <= S_OP2;
          end
        end else begin
          r_state[p] <= S_IDLE;
        end
        if (w_push[p]) begin
          r_fifo[p][r_wr_ptr[p]] <= {r_cmd_l[p], r_tag_l[p], r_op1_l[p], w_data[p]};
          r_wr_ptr[p] <= r_wr_ptr[p] + PTR_W'(1);
        end
        if (w_pop[p]) r_rd_ptr[p] <= r_rd_ptr[p] + PTR_W'(1);
        if (w_push[p] && !w_pop[p])      r_count[p] <= r_count[p] + CNT_W'(1);
        else if (!w_push[p] && w_pop[p]) r_count[p] <= r_count[p] - CNT_W'(1);

        // A port has at most one head in flight, so the two units never target it together.
        r_resp[p] <= C_NONE;
        r_dout[p] <= '0;
        r_tago[p] <= '0;
        if (r_as_vld && r_as_port == 2'(p)) begin
          r_resp[p] <= w_as_resp;
          r_dout[p] <= w_as_data;
          r_tago[p] <= r_as_tag;
        end
        if (r_sh_vld && r_sh_port == 2'(p)) begin
          r_resp[p] <= w_sh_resp;
          r_dout[p] <= w_sh_data;
          r_tago[p] <= r_sh_tag;
        end
      end

      r_as_vld <= w_pick_as[2];
      if (w_pick_as[2]) begin
        r_rr_as   <= w_pick_as[1:0];
        r_as_port <= w_pick_as[1:0];
        r_as_sub  <= (w_head_cmd[w_pick_as[1:0]] == C_SUB);
        r_as_tag  <= w_head[w_pick_as[1:0]][ENT_W-5 -: 2];
        r_as_a    <= w_head[w_pick_as[1:0]][2*DATA_W-1 -: DATA_W];
        r_as_b    <= w_head[w_pick_as[1:0]][DATA_W-1:0];
      end
      r_sh_vld <= w_pick_sh[2];
      if (w_pick_sh[2]) begin
        r_rr_sh   <= w_pick_sh[1:0];
        r_sh_port <= w_pick_sh[1:0];
        r_sh_cmd  <= w_head_cmd[w_pick_sh[1:0]];
        r_sh_tag  <= w_head[w_pick_sh[1:0]][ENT_W-5 -: 2];
        r_sh_a    <= w_head[w_pick_sh[1:0]][2*DATA_W-1 -: DATA_W];
        r_sh_amt  <= w_head[w_pick_sh[1:0]][SH_W-1:0];
      end
    end
  end

  assign out_resp1 = r_resp[0];  assign out_data1 = r_dout[0];  assign out_tag1 = r_tago[0];
  assign out_resp2 = r_resp[1];  assign out_data2 = r_dout[1];  assign out_tag2 = r_tago[1];
  assign out_resp3 = r_resp[2];  assign out_data3 = r_dout[2];  assign out_tag3 = r_tago[2];
  assign out_resp4 = r_resp[3];  assign out_data4 = r_dout[3];  assign out_tag4 = r_tago[3];

endmodule
`default_nettype wire

// File: tb/tb_calc2_engine.sv
`default_nettype none
// ==== tb_calc2_engine : directed scoreboard bench for calc2_engine ====
// ==== Rev 1.0                                                      ====
module tb_calc2_engine;
  localparam logic [3:0] C_ADD = 4'd1;
  localparam logic [3:0] C_SUB = 4'd2;
  localparam logic [3:0] C_SHL = 4'd5;
  localparam logic [3:0] C_SHR = 4'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cmd  [4];
  logic [31:0] din  [4];
  logic [1:0]  tin  [4];
  logic [1:0]  resp_o [4];
  logic [31:0] dout   [4];
  logic [1:0]  tout   [4];

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    int          exact;
    int          deadline;
  } exp_t;

  exp_t sbq [4][$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc2_engine #(.DATA_W(32), .FIFO_DEPTH(4)) dut (
    .c_clk(clk), .reset(rst),
    .req1_cmd_in(cmd[0]), .req1_data_in(din[0]), .req1_tag_in(tin[0]),
    .req2_cmd_in(cmd[1]), .req2_data_in(din[1]), .req2_tag_in(tin[1]),
    .req3_cmd_in(cmd[2]), .req3_data_in(din[2]), .req3_tag_in(tin[2]),
    .req4_cmd_in(cmd[3]), .req4_data_in(din[3]), .req4_tag_in(tin[3]),
    .out_resp1(resp_o[0]), .out_data1(dout[0]), .out_tag1(tout[0]),
    .out_resp2(resp_o[1]), .out_data2(dout[1]), .out_tag2(tout[1]),
    .out_resp3(resp_o[2]), .out_data3(dout[2]), .out_tag3(tout[2]),
    .out_resp4(resp_o[3]), .out_data4(dout[3]), .out_tag4(tout[3])
  );

  function automatic int pending();
    int n = 0;
    for (int p = 0; p < 4; p++) n += sbq[p].size();
    return n;
  endfunction

  task automatic expect_rsp(input int p, input logic [1:0] r, input logic [31:0] d,
                            input logic [1:0] t, input int exact, input int deadline);
    exp_t e;
    e.resp = r; e.data = d; e.tag = t; e.exact = exact; e.deadline = deadline;
    sbq[p].push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the op2 edge with the expectation queued.
  task automatic issue(input int p, input logic [3:0] c, input logic [1:0] t,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] er, input logic [31:0] ed);
    cmd[p] = c; din[p] = a; tin[p] = t;
    @(posedge clk); #1;
    cmd[p] = 4'd0; din[p] = b; tin[p] = 2'd0;
    @(posedge clk); #1;
    din[p] = 32'd0;
    expect_rsp(p, er, ed, t, cyc + 2, cyc + 2);
  endtask

  task automatic wait_drain(input int max_cyc);
    int i = 0;
    while (pending() != 0 && i < max_cyc) begin
      @(posedge clk); #1;
      i++;
    end
    n_vec++;
    assert (pending() == 0) else begin
      n_err++;
      $error("FAIL drain_timeout: %0d responses outstanding, required 0", pending());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   lat_ok;
    if (!rst) begin
      for (int p = 0; p < 4; p++) begin
        if (resp_o[p] != 2'd0) begin
          n_vec++;
          assert (sbq[p].size() > 0) else begin
            n_err++;
            $error("FAIL unexpected_resp port%0d: got resp=%0d data=%h tag=%0d, required none",
                   p + 1, resp_o[p], dout[p], tout[p]);
          end
          if (sbq[p].size() > 0) begin
            e = sbq[p].pop_front();
            n_vec++;
            assert (resp_o[p] === e.resp && dout[p] === e.data && tout[p] === e.tag) else begin
              n_err++;
              $error("FAIL result port%0d: got resp=%0d data=%h tag=%0d, required resp=%0d data=%h tag=%0d",
                     p + 1, resp_o[p], dout[p], tout[p], e.resp, e.data, e.tag);
            end
            lat_ok = (e.exact >= 0) ? (cyc == e.exact) : (cyc <= e.deadline);
            n_vec++;
            assert (lat_ok) else begin
              n_err++;
              $error("FAIL latency port%0d: got cycle %0d, required exact=%0d deadline=%0d",
                     p + 1, cyc, e.exact, e.deadline);
            end
          end
        end else begin
          n_vec++;
          assert (dout[p] === 32'd0 && tout[p] === 2'd0) else begin
            n_err++;
            $error("FAIL idle_outputs port%0d: got data=%h tag=%0d, required 0/0",
                   p + 1, dout[p], tout[p]);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0; din[p] = 32'd0; tin[p] = 2'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      n_vec++;
      assert (resp_o[p] === 2'd0 && dout[p] === 32'd0 && tout[p] === 2'd0) else begin
        n_err++;
        $error("FAIL reset_state port%0d: got resp=%0d data=%h tag=%0d, required 0/0/0",
               p + 1, resp_o[p], dout[p], tout[p]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic add on port 1
    issue(0, C_ADD, 2'd1, 32'h30, 32'h20, 2'd1, 32'h50);
    wait_drain(20);

    // Port 2: carry overflow, normal sub, underflow
    issue(1, C_ADD, 2'd0, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'd0);
    issue(1, C_SUB, 2'd1, 32'h30, 32'h20, 2'd1, 32'h10);
    issue(1, C_SUB, 2'd2, 32'd5, 32'd6, 2'd2, 32'd0);
    wait_drain(20);

    // Port 3: shifts; amount uses only the low five bits
    issue(2, C_SHL, 2'd3, 32'h1, 32'd31, 2'd1, 32'h8000_0000);
    issue(2, C_SHR, 2'd0, 32'h8000_0000, 32'h24, 2'd1, 32'h0800_0000);
    wait_drain(20);

    // Port 4: invalid command, equal-operand sub, then idle no-op cycles
    issue(3, 4'd3, 2'd2, 32'h1234, 32'h5678, 2'd2, 32'd0);
    issue(3, C_SUB, 2'd1, 32'd7, 32'd7, 2'd1, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    wait_drain(20);

    // All four ports contend for the ADD/SUB unit in the same cycle
    for (int p = 0; p < 4; p++) begin
      cmd[p] = C_ADD; din[p] = 32'(32'h100 * (p + 1)); tin[p] = 2'(p);
    end
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0; din[p] = 32'(p + 7); tin[p] = 2'd0;
    end
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++) begin
      din[p] = 32'd0;
      expect_rsp(p, 2'd1, 32'(32'h100 * (p + 1) + p + 7), 2'(p), -1, cyc + 10);
    end
    wait_drain(20);

    // Reset with a port-1 request half-issued and a port-3 shift about to dispatch
    cmd[2] = C_SHL; din[2] = 32'h3; tin[2] = 2'd1;
    @(posedge clk); #1;
    cmd[2] = 4'd0; din[2] = 32'd2; tin[2] = 2'd0;
    cmd[0] = C_ADD; din[0] = 32'h55; tin[0] = 2'd2;
    @(posedge clk); #1;
    din[2] = 32'd0;
    cmd[0] = 4'd0; din[0] = 32'h66; tin[0] = 2'd0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    din[0] = 32'd0;
    repeat (6) @(posedge clk);
    #1;
    issue(0, C_ADD, 2'd3, 32'h1234, 32'h1, 2'd1, 32'h1235);
    wait_drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
